// File: rtl/bubble_pkg.sv
// Shared types and widths for the bubble launch path (spawner and mover array).
package bubble_pkg;

  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned COORD_W = 11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH_L,
    HOLD_L,
    LAUNCH_R,
    HOLD_R
  } spawn_state_t;

endpackage

// File: rtl/slot_alloc.sv
// Picks the lowest-index mover that is neither busy nor recently launched.
module slot_alloc #(
  parameter int unsigned N_SLOTS = 8
) (
  input  logic [N_SLOTS-1:0] slot_busy_i,
  input  logic [N_SLOTS-1:0] reserved_i,
  output logic [N_SLOTS-1:0] grant_o,
  output logic               found_o
);

  logic [N_SLOTS-1:0] free;

  assign free = ~(slot_busy_i | reserved_i);

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (!found_o && free[k]) begin
        grant_o[k] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bubble_spawner.sv
// Launches the initial bubble and the left/right children of each split
// into free mover slots over the shared start/direction/position/size bus.
module bubble_spawner
  import bubble_pkg::*;
#(
  parameter int unsigned N_SLOTS  = 8,
  parameter int unsigned MAX_SIZE = 3,
  parameter int unsigned LEVEL_X  = 300,
  parameter int unsigned LEVEL_Y  = 100
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               level_start,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  logic [SIZE_W-1:0]  hit_size,
  input  logic [COORD_W-1:0] hit_topX,
  input  logic [COORD_W-1:0] hit_topY,
  input  logic [N_SLOTS-1:0] slot_busy,
  output logic [N_SLOTS-1:0] start,
  output logic               direction,
  output logic [COORD_W-1:0] startTopX,
  output logic [COORD_W-1:0] startTopY,
  output logic [SIZE_W-1:0]  size_out,
  output logic               drop,
  output logic               level_clear
);

  spawn_state_t       state_q, state_d;
  logic [N_SLOTS-1:0] start_q, start_d, start_prev_q;
  logic               dir_q, dir_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic               drop_q, drop_d;
  logic               level_clear_q, level_clear_d;
  logic               hit_ready_q;

  logic [N_SLOTS-1:0] reserved;
  logic [N_SLOTS-1:0] grant;
  logic               found;
  logic               accept;

  // A slot stays reserved for the launch cycle and the one after, covering the
  // mover's one-cycle lag before it reports busy.
  assign reserved = start_q | start_prev_q;

  slot_alloc #(.N_SLOTS(N_SLOTS)) u_alloc (
    .slot_busy_i (slot_busy),
    .reserved_i  (reserved),
    .grant_o     (grant),
    .found_o     (found)
  );

  // level_start wins over a hit in the same cycle, so ready is masked by it.
  assign hit_ready = hit_ready_q & ~level_start;
  assign accept    = hit_valid & hit_ready;

  always_comb begin
    state_d       = state_q;
    start_d       = '0;
    drop_d        = 1'b0;
    dir_d         = dir_q;
    x_d           = x_q;
    y_d           = y_q;
    size_d        = size_q;
    level_clear_d = (state_q == IDLE) && ((slot_busy | reserved) == '0);

    case (state_q)
      IDLE: begin
        if (level_start) begin
          x_d     = COORD_W'(LEVEL_X);
          y_d     = COORD_W'(LEVEL_Y);
          size_d  = SIZE_W'(MAX_SIZE);
          state_d = LAUNCH_R;
        end else if (accept && (hit_size != '0)) begin
          x_d     = hit_topX;
          y_d     = hit_topY;
          size_d  = hit_size - SIZE_W'(1);
          state_d = LAUNCH_L;
        end
      end
      LAUNCH_L: begin
        dir_d   = DIR_LEFT;
        start_d = grant;
        drop_d  = ~found;
        state_d = HOLD_L;
      end
      HOLD_L: state_d = LAUNCH_R;
      LAUNCH_R: begin
        dir_d   = DIR_RIGHT;
        start_d = grant;
        drop_d  = ~found;
        state_d = HOLD_R;
      end
      HOLD_R: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= IDLE;
      start_q       <= '0;
      start_prev_q  <= '0;
      dir_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      size_q        <= '0;
      drop_q        <= 1'b0;
      level_clear_q <= 1'b0;
      hit_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      start_prev_q  <= start_q;
      dir_q         <= dir_d;
      x_q           <= x_d;
      y_q           <= y_d;
      size_q        <= size_d;
      drop_q        <= drop_d;
      level_clear_q <= level_clear_d;
      hit_ready_q   <= (state_d == IDLE);
    end
  end

  assign start       = start_q;
  assign direction   = dir_q;
  assign startTopX   = x_q;
  assign startTopY   = y_q;
  assign size_out    = size_q;
  assign drop        = drop_q;
  assign level_clear = level_clear_q;

endmodule

// File: tb/tb_bubble_spawner.sv
// Self-checking bench for bubble_spawner: directed vector table, hand-written
// corner sequences, and a randomized run against a timeline reference model.
module tb_bubble_spawner;

  logic        clk = 1'b0;
  logic        resetN;
  logic        level_start;
  logic        hit_valid;
  logic        hit_ready;
  logic [2:0]  hit_size;
  logic [10:0] hit_topX;
  logic [10:0] hit_topY;
  logic [7:0]  slot_busy;
  logic [7:0]  start;
  logic        direction;
  logic [10:0] startTopX;
  logic [10:0] startTopY;
  logic [2:0]  size_out;
  logic        drop;
  logic        level_clear;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bubble_spawner #(
    .N_SLOTS  (8),
    .MAX_SIZE (3),
    .LEVEL_X  (300),
    .LEVEL_Y  (100)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .level_start (level_start),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_size    (hit_size),
    .hit_topX    (hit_topX),
    .hit_topY    (hit_topY),
    .slot_busy   (slot_busy),
    .start       (start),
    .direction   (direction),
    .startTopX   (startTopX),
    .startTopY   (startTopY),
    .size_out    (size_out),
    .drop        (drop),
    .level_clear (level_clear)
  );

  typedef struct {
    logic        ls, hv;
    logic [2:0]  hs;
    logic [10:0] hx, hy;
    logic [7:0]  busy;
    logic [7:0]  e_start;
    logic        e_dir, dchk;
    logic [10:0] e_x, e_y;
    logic [2:0]  e_sz;
    logic        e_drop, e_rdy, e_lc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic ls, hv, input logic [2:0] hs,
                              input logic [10:0] hx, hy, input logic [7:0] busy,
                              input logic [7:0] st, input logic d, dchk,
                              input logic [10:0] x, y, input logic [2:0] sz,
                              input logic dr, rdy, lc);
    vec_t v;
    v.ls = ls; v.hv = hv; v.hs = hs; v.hx = hx; v.hy = hy; v.busy = busy;
    v.e_start = st; v.e_dir = d; v.dchk = dchk; v.e_x = x; v.e_y = y;
    v.e_sz = sz; v.e_drop = dr; v.e_rdy = rdy; v.e_lc = lc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ls, hv, input logic [2:0] hs,
                       input logic [10:0] hx, hy, input logic [7:0] busy);
    level_start = ls; hit_valid = hv; hit_size = hs;
    hit_topX = hx; hit_topY = hy; slot_busy = busy;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, 32'(start), 32'h0);
    chk({tag, "_dir"}, 32'(direction), 32'h0);
    chk({tag, "_x"}, 32'(startTopX), 32'h0);
    chk({tag, "_y"}, 32'(startTopY), 32'h0);
    chk({tag, "_size"}, 32'(size_out), 32'h0);
    chk({tag, "_drop"}, 32'(drop), 32'h0);
    chk({tag, "_lc"}, 32'(level_clear), 32'h0);
  endtask

  // Reference model: a timeline of scheduled launch edges rather than a state machine.
  int          cyc, idle_from, left_at, right_at, last_dec;
  logic [7:0]  l1, l2;
  logic [10:0] mx, my;
  logic [2:0]  ms;
  logic        md;

  task automatic model_init();
    cyc = 0; idle_from = 0; left_at = -1; right_at = -1; last_dec = -10;
    l1 = '0; l2 = '0; mx = '0; my = '0; ms = '0; md = 1'b0;
  endtask

  task automatic model_step(output logic [7:0] e_start, output logic e_drop,
                            output logic e_lc, output bit acc);
    logic [7:0] res, free;
    bit         idle;
    res  = l1 | l2;
    idle = (cyc >= idle_from);
    e_lc = idle && ((slot_busy | res) == 8'h00);
    e_start = '0; e_drop = 1'b0; acc = 0;
    if (cyc == left_at || cyc == right_at) begin
      md = (cyc == right_at);
      last_dec = cyc;
      free = ~(slot_busy | res);
      if (free == 8'h00) e_drop = 1'b1;
      else begin
        for (int k = 0; k < 8; k++) if (free[k]) begin e_start = 8'(1 << k); break; end
      end
    end
    if (idle) begin
      if (level_start) begin
        mx = 11'd300; my = 11'd100; ms = 3'd3;
        right_at = cyc + 1; idle_from = cyc + 3;
      end else if (hit_valid) begin
        acc = 1;
        if (hit_size != 0) begin
          mx = hit_topX; my = hit_topY; ms = hit_size - 3'd1;
          left_at = cyc + 1; right_at = cyc + 3; idle_from = cyc + 5;
        end
      end
    end
    l2 = l1; l1 = e_start;
  endtask

  initial begin
    logic [7:0] e_start;
    logic       e_drop, e_lc;
    bit         acc, pend;
    logic [2:0] rs;
    logic [10:0] rx, ry;

    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00);
    tick();
    tick();
    chk_reset_outs("reset");

    //     ls hv hs  hx   hy   busy   st    d dc  x    y   sz dr rdy lc
    tbl[0]  = mk(1, 0, 0,   0,   0, 8'h00, 8'h00, 0, 0, 300, 100, 3, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0,   0,   0, 8'h00, 8'h01, 1, 1, 300, 100, 3, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,   0,   0, 8'h00, 8'h00, 1, 1, 300, 100, 3, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0,   0,   0, 8'h01, 8'h00, 1, 0, 300, 100, 3, 0, 1, 0);
    tbl[4]  = mk(0, 1, 3, 200, 150, 8'h01, 8'h00, 0, 0, 200, 150, 2, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,   0,   0, 8'h01, 8'h02, 0, 1, 200, 150, 2, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,   0,   0, 8'h03, 8'h00, 0, 1, 200, 150, 2, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,   0,   0, 8'h03, 8'h04, 1, 1, 200, 150, 2, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,   0,   0, 8'h07, 8'h00, 1, 1, 200, 150, 2, 0, 1, 0);
    tbl[9]  = mk(0, 1, 0,  77,  88, 8'h07, 8'h00, 0, 0, 200, 150, 2, 0, 1, 0);
    tbl[10] = mk(0, 0, 0,   0,   0, 8'h00, 8'h00, 0, 0, 200, 150, 2, 0, 1, 1);
    tbl[11] = mk(0, 1, 2,  40,  60, 8'hFE, 8'h00, 0, 0,  40,  60, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,   0,   0, 8'hFE, 8'h01, 0, 1,  40,  60, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0,   0,   0, 8'hFE, 8'h00, 0, 1,  40,  60, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,   0,   0, 8'hFE, 8'h00, 1, 1,  40,  60, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,   0,   0, 8'hFE, 8'h00, 1, 1,  40,  60, 1, 0, 1, 0);

    resetN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ls, tbl[i].hv, tbl[i].hs, tbl[i].hx, tbl[i].hy, tbl[i].busy);
      tick();
      chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].e_start));
      if (tbl[i].dchk) chk($sformatf("tbl%0d_dir", i), 32'(direction), 32'(tbl[i].e_dir));
      chk($sformatf("tbl%0d_x", i), 32'(startTopX), 32'(tbl[i].e_x));
      chk($sformatf("tbl%0d_y", i), 32'(startTopY), 32'(tbl[i].e_y));
      chk($sformatf("tbl%0d_size", i), 32'(size_out), 32'(tbl[i].e_sz));
      chk($sformatf("tbl%0d_drop", i), 32'(drop), 32'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_ready", i), 32'(hit_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_lc", i), 32'(level_clear), 32'(tbl[i].e_lc));
    end

    // level_start and a hit together: initial bubble first, hit held and taken afterwards.
    drive(1, 1, 3, 500, 20, 8'h00);
    #1 chk("prio_ready_masked", 32'(hit_ready), 32'h0);
    tick();
    chk("prio_x_initial", 32'(startTopX), 32'd300);
    chk("prio_size_initial", 32'(size_out), 32'd3);
    level_start = 1'b0;
    #1 chk("prio_ready_busy", 32'(hit_ready), 32'h0);
    tick();
    chk("prio_start_initial", 32'(start), 32'h01);
    chk("prio_dir_initial", 32'(direction), 32'h1);
    slot_busy = 8'h01;
    tick();
    chk("prio_ready_back", 32'(hit_ready), 32'h1);
    tick();
    chk("prio_x_hit", 32'(startTopX), 32'd500);
    chk("prio_size_hit", 32'(size_out), 32'd2);
    hit_valid = 1'b0;
    tick();
    chk("prio_start_left", 32'(start), 32'h02);
    chk("prio_dir_left", 32'(direction), 32'h0);
    tick();
    tick();
    chk("prio_start_right", 32'(start), 32'h04);
    chk("prio_dir_right", 32'(direction), 32'h1);
    tick();

    // Reset while holding the left child: no right launch afterwards.
    drive(0, 1, 1, 7, 9, 8'h00);
    tick();
    hit_valid = 1'b0;
    tick();
    chk("rst6_left", 32'(start), 32'h01);
    resetN = 1'b0;
    tick();
    chk_reset_outs("rst6");
    resetN = 1'b1;
    #1 chk("rst6_ready", 32'(hit_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst6_nostart%0d", i), 32'(start), 32'h0);
    end

    // Randomized run against the timeline model.
    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00);
    tick();
    tick();
    resetN = 1'b1;
    model_init();
    pend = 0; rs = '0; rx = '0; ry = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        rs = 3'($urandom_range(0, 7));
        rx = 11'($urandom_range(0, 2047));
        ry = 11'($urandom_range(0, 2047));
      end
      drive(($urandom_range(0, 39) == 0), pend, rs, rx, ry,
            ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom & $urandom & $urandom));
      #1 chk("rnd_ready", 32'(hit_ready), 32'((cyc >= idle_from) && !level_start));
      model_step(e_start, e_drop, e_lc, acc);
      if (acc) pend = 0;
      tick();
      chk("rnd_start", 32'(start), 32'(e_start));
      chk("rnd_drop", 32'(drop), 32'(e_drop));
      chk("rnd_lc", 32'(level_clear), 32'(e_lc));
      chk("rnd_x", 32'(startTopX), 32'(mx));
      chk("rnd_y", 32'(startTopY), 32'(my));
      chk("rnd_size", 32'(size_out), 32'(ms));
      if (last_dec == cyc || last_dec == cyc - 1) chk("rnd_dir", 32'(direction), 32'(md));
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
